// File: rtl/instr_mem_loader.sv
// Packs a stream of HOST_W-bit host words into INSTR_W-bit instruction words
// and writes them to consecutive instruction memory addresses from a base.
module instr_mem_loader #(
   parameter int HOST_W  = 32,
   parameter int INSTR_W = 128,
   parameter int ADDR_W  = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [ADDR_W:0]    n_instr,
   input  logic               host_valid,
   input  logic [HOST_W-1:0]  host_data,
   output logic               host_ready,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [INSTR_W-1:0] mem_wdata,
   output logic               busy,
   output logic               done
);

   localparam int PACK  = INSTR_W / HOST_W;
   localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACK - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_LAST_WR = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [INSTR_W-1:0] pack_q, pack_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  maddr_q, maddr_d;
   logic [INSTR_W-1:0] wdata_q, wdata_d;

   // Next-state, packing and write-port staging
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pack_d  = pack_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      maddr_d = maddr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (n_instr != {CNT_W{1'b0}}) begin
                  state_d = S_LOAD;
                  addr_d  = base_addr;
                  cnt_d   = n_instr;
                  idx_d   = {IDX_W{1'b0}};
                  pack_d  = {INSTR_W{1'b0}};
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_IDLE;
               idx_d   = {IDX_W{1'b0}};
               pack_d  = {INSTR_W{1'b0}};
            end else if (host_valid) begin
               pack_d[int'(idx_q)*HOST_W +: HOST_W] = host_data;
               // Final slice completes the word: stage the write and clear the pack.
               if (idx_q == LAST_IDX) begin
                  we_d    = 1'b1;
                  maddr_d = addr_q;
                  wdata_d = pack_d;
                  addr_d  = addr_q + ADDR_W'(1);
                  cnt_d   = cnt_q - CNT_W'(1);
                  idx_d   = {IDX_W{1'b0}};
                  pack_d  = {INSTR_W{1'b0}};
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = S_LAST_WR;
                  end else begin
                     state_d = S_LOAD;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_LAST_WR: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= {IDX_W{1'b0}};
         pack_q  <= {INSTR_W{1'b0}};
         addr_q  <= {ADDR_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         we_q    <= 1'b0;
         maddr_q <= {ADDR_W{1'b0}};
         wdata_q <= {INSTR_W{1'b0}};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pack_q  <= pack_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign host_ready = (state_q == S_LOAD);
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign mem_we     = we_q;
   assign mem_addr   = maddr_q;
   assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued by the
// driver and checked by a monitor whenever mem_we is observed.
module tb_instr_mem_loader;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         abort;
   logic [9:0]   base_addr;
   logic [10:0]  n_instr;
   logic         host_valid;
   logic [31:0]  host_data;
   logic         host_ready;
   logic         mem_we;
   logic [9:0]   mem_addr;
   logic [127:0] mem_wdata;
   logic         busy;
   logic         done;

   typedef struct packed {
      logic [9:0]   a;
      logic [127:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   last_we_cyc = 0;
   bit   ready_seen = 1'b0;

   instr_mem_loader #(.HOST_W(32), .INSTR_W(128), .ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .base_addr(base_addr), .n_instr(n_instr),
      .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops an expected write for every observed mem_we
   always @(negedge clk) begin
      exp_t e;
      if (host_ready) ready_seen = 1'b1;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (mem_we) begin
         last_we_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr=%h data=%h expected no write", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("write_addr", 128'(mem_addr), 128'(e.a));
            chk("write_data", mem_wdata, e.d);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [9:0] b, input logic [10:0] n);
      start = 1'b1;
      base_addr = b;
      n_instr = n;
      tick();
      start = 1'b0;
   endtask

   task automatic send_words(input logic [31:0] first, input int n, input bit toggle);
      for (int i = 0; i < n; i++) begin
         bit acc = 1'b0;
         int to = 0;
         host_valid = 1'b1;
         host_data = first + 32'(i);
         while (!acc) begin
            bit rdy = host_ready;
            tick();
            if (rdy) begin
               acc = 1'b1;
            end else if (++to > 20) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout: got no acceptance expected word %0d accepted", i);
               host_valid = 1'b0;
               return;
            end
         end
         host_valid = 1'b0;
         if (toggle) tick();
      end
   endtask

   task automatic wait_done(input int prev);
      for (int i = 0; i < 10; i++) begin
         if (done_cnt > prev) break;
         tick();
      end
      chk("done_seen", 128'(done_cnt), 128'(prev + 1));
   endtask

   initial begin
      int prev;
      int st_cyc;
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      base_addr = 10'h000; n_instr = 11'd0;
      host_valid = 1'b0; host_data = 32'h0;
      #2;
      chk("reset_busy", 128'(busy), 128'd0);
      chk("reset_ready", 128'(host_ready), 128'd0);
      chk("reset_we", 128'(mem_we), 128'd0);
      tick(); tick();
      rst = 1'b1;
      tick();

      // Back-to-back load of two instructions
      exp_q.push_back('{a: 10'h010, d: 128'h00000004_00000003_00000002_00000001});
      exp_q.push_back('{a: 10'h011, d: 128'h00000008_00000007_00000006_00000005});
      prev = done_cnt;
      start_load(10'h010, 11'd2);
      send_words(32'h1, 8, 1'b0);
      chk("ready_low_after_last", 128'(host_ready), 128'd0);
      wait_done(prev);
      chk("done_after_last_write", 128'(done_cyc), 128'(last_we_cyc + 1));
      chk("t1_all_writes", 128'(exp_q.size()), 128'd0);
      tick();

      // Same load, host_valid toggling
      exp_q.push_back('{a: 10'h010, d: 128'h00000004_00000003_00000002_00000001});
      exp_q.push_back('{a: 10'h011, d: 128'h00000008_00000007_00000006_00000005});
      prev = done_cnt;
      start_load(10'h010, 11'd2);
      send_words(32'h1, 8, 1'b1);
      wait_done(prev);
      chk("t2_all_writes", 128'(exp_q.size()), 128'd0);
      tick();

      // Address wrap
      exp_q.push_back('{a: 10'h3FF, d: 128'h00000014_00000013_00000012_00000011});
      exp_q.push_back('{a: 10'h000, d: 128'h00000018_00000017_00000016_00000015});
      prev = done_cnt;
      start_load(10'h3FF, 11'd2);
      send_words(32'h11, 8, 1'b0);
      wait_done(prev);
      chk("t3_all_writes", 128'(exp_q.size()), 128'd0);
      tick();

      // Zero-length load
      ready_seen = 1'b0;
      prev = done_cnt;
      st_cyc = cyc;
      start_load(10'h040, 11'd0);
      wait_done(prev);
      chk("zero_done_latency_ok", 128'((done_cyc - st_cyc) >= 1 && (done_cyc - st_cyc) <= 2), 128'd1);
      chk("zero_no_ready", 128'(ready_seen), 128'd0);
      tick();

      // Abort after six words, then a fresh single-instruction load
      exp_q.push_back('{a: 10'h010, d: 128'h00000004_00000003_00000002_00000001});
      prev = done_cnt;
      start_load(10'h010, 11'd2);
      send_words(32'h1, 6, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy_low", 128'(busy), 128'd0);
      tick(); tick(); tick();
      chk("abort_no_done", 128'(done_cnt), 128'(prev));
      chk("abort_one_write", 128'(exp_q.size()), 128'd0);
      exp_q.push_back('{a: 10'h020, d: 128'h000000A4_000000A3_000000A2_000000A1});
      start_load(10'h020, 11'd1);
      send_words(32'hA1, 4, 1'b0);
      wait_done(prev);
      chk("fresh_write", 128'(exp_q.size()), 128'd0);
      tick();

      // Asynchronous reset mid-load
      prev = done_cnt;
      start_load(10'h010, 11'd2);
      send_words(32'h1, 3, 1'b0);
      rst = 1'b0;
      #1;
      chk("rst_ready", 128'(host_ready), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_outs", 128'({mem_we, done, mem_addr}), 128'd0);
      chk("rst_wdata", mem_wdata, 128'd0);
      tick();
      start = 1'b1; base_addr = 10'h010; n_instr = 11'd1;
      tick();
      start = 1'b0;
      chk("rst_start_ignored", 128'(busy), 128'd0);
      rst = 1'b1;
      tick(); tick(); tick();
      chk("post_rst_idle", 128'(busy), 128'd0);
      chk("rst_no_done", 128'(done_cnt), 128'(prev));

      chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
